// File: rtl/final_module_sys.sv
// Vector-coprocessor demo: program ROM, micro-sequencer, 4x VLEN vector regfile,
// element-serial ALU and 32-bit accumulator. Define RETIRE_LOG_EN for a sim-only retire trace.

module final_module_sys_alu #(
  parameter int ELEN = 8
) (
  input  logic [3:0]      op,
  input  logic [ELEN-1:0] a,
  input  logic [ELEN-1:0] b,
  input  logic [ELEN-1:0] imm,
  input  logic [ELEN-1:0] idx,
  output logic [ELEN-1:0] y
);
  localparam logic [3:0] OP_VSPLAT = 4'h1;
  localparam logic [3:0] OP_VADD   = 4'h2;
  localparam logic [3:0] OP_VMUL   = 4'h3;
  localparam logic [3:0] OP_VSUB   = 4'h4;
  localparam logic [3:0] OP_VIDX   = 4'h6;

  always_comb begin
    y = '0;
    case (op)
      OP_VSPLAT: y = imm;
      OP_VADD:   y = a + b;
      OP_VMUL:   y = ELEN'(a * b);
      OP_VSUB:   y = a - b;
      OP_VIDX:   y = idx + imm;
      default:   y = '0;
    endcase
  end
endmodule

module final_module_sys #(
  parameter int VLEN      = 4,
  parameter int ELEN      = 8,
  parameter int ROM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        done,
  output logic        trap,
  output logic [31:0] result
);
  localparam int PW = $clog2(ROM_DEPTH);
  localparam int EW = (VLEN > 1) ? $clog2(VLEN) : 1;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_VREDSUM = 4'h5;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_DONE} state_t;

  // imm[7:6] doubles as vs2 for register-register ops
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] vd;
    logic [1:0] vs1;
    logic [7:0] imm;
  } insn_t;

  state_t                               state, state_nxt;
  insn_t                                ir;
  logic [PW-1:0]                        pc;
  logic [EW-1:0]                        elem;
  logic [31:0]                          acc;
  logic [3:0][VLEN-1:0][ELEN-1:0]       vreg;
  logic [15:0]                          rom_word;
  logic [ELEN-1:0]                      elem_a, elem_b, alu_y;
  logic                                 is_vec, last_elem;
  logic                                 fetch_en, vwe, acc_add, elem_step;
  logic                                 set_done, set_trap, retire;

  function automatic logic [15:0] rom_f(input logic [PW-1:0] a);
    case (int'(a))
      0:       rom_f = 16'h6001;  // VIDX    v0, 1
      1:       rom_f = 16'h1403;  // VSPLAT  v1, 3
      2:       rom_f = 16'h3840;  // VMUL    v2, v0, v1
      3:       rom_f = 16'h2E00;  // VADD    v3, v2, v0
      4:       rom_f = 16'h5300;  // VREDSUM v3
      5:       rom_f = 16'h4900;  // VSUB    v2, v1, v0
      6:       rom_f = 16'h5200;  // VREDSUM v2
      7:       rom_f = 16'hF000;  // HALT
      default: rom_f = 16'h0000;
    endcase
  endfunction

  assign rom_word  = rom_f(pc);
  assign elem_a    = vreg[ir.vs1][elem];
  assign elem_b    = vreg[ir.imm[7:6]][elem];
  assign is_vec    = (ir.op >= 4'h1) && (ir.op <= 4'h6);
  assign last_elem = (elem == EW'(VLEN-1));
  assign result    = acc;

  final_module_sys_alu #(.ELEN(ELEN)) u_alu (
    .op  (ir.op),
    .a   (elem_a),
    .b   (elem_b),
    .imm (ir.imm[ELEN-1:0]),
    .idx ({{(ELEN-EW){1'b0}}, elem}),
    .y   (alu_y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    vwe       = 1'b0;
    acc_add   = 1'b0;
    elem_step = 1'b0;
    set_done  = 1'b0;
    set_trap  = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_en  = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_vec) begin
          elem_step = 1'b1;
          acc_add   = (ir.op == OP_VREDSUM);
          vwe       = (ir.op != OP_VREDSUM);
          if (last_elem) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (ir.op == OP_NOP) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          retire    = 1'b1;
          set_done  = (ir.op == OP_HALT);
          set_trap  = (ir.op != OP_HALT);
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_DONE;
    endcase
  end

  // Each element reads and writes only its own index, so vd==vs never sees a new value early
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir   <= '0;
      pc   <= '0;
      elem <= '0;
      acc  <= '0;
      vreg <= '0;
      done <= 1'b0;
      trap <= 1'b0;
    end else begin
      if (fetch_en) begin
        ir   <= insn_t'(rom_word);
        pc   <= (pc == PW'(ROM_DEPTH-1)) ? '0 : pc + 1'b1;
        elem <= '0;
      end
      if (elem_step) elem <= last_elem ? '0 : elem + 1'b1;
      if (vwe)       vreg[ir.vd][elem] <= alu_y;
      if (acc_add)   acc <= acc + {{(32-ELEN){1'b0}}, elem_a};
      if (set_done)  done <= 1'b1;
      if (set_trap)  trap <= 1'b1;
    end
  end

`ifdef RETIRE_LOG_EN
  logic [PW-1:0] retire_pc;
  logic [31:0]   retire_acc;
  assign retire_pc  = pc - 1'b1;
  assign retire_acc = acc_add ? acc + {{(32-ELEN){1'b0}}, elem_a} : acc;
  always_ff @(posedge clk) begin
    if (resetn && retire)
      $display("retire pc=%h op=%h acc=%h", retire_pc, ir.op, retire_acc);
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif
endmodule

// File: tb/tb_final_module_sys.sv
// Directed bench for final_module_sys: program results, done timing, mid-run reset, forced trap.

module tb_final_module_sys;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        done, trap;
  logic [31:0] result;
  int          n_chk = 0;
  int          n_fail = 0;

  final_module_sys dut (
    .clk    (clk),
    .resetn (resetn),
    .done   (done),
    .trap   (trap),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic edge_n();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_chk++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got=%b exp=0", trap); end
    n_chk++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    n_chk++; if (dut.pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got=%0d exp=0", dut.pc); end
    n_chk++; if (dut.vreg !== 128'd0) begin n_fail++; $display("FAIL reset_vreg got=%h exp=0", dut.vreg); end
  endtask

  task automatic test_program();
    @(negedge clk) resetn = 1'b1;
    for (int e = 1; e <= 37; e++) begin
      edge_n();
      if (e == 20) begin
        n_chk++; if (dut.vreg[3] !== 32'h100C0804) begin n_fail++; $display("FAIL prog_v3 got=%h exp=100c0804", dut.vreg[3]); end
        n_chk++; if (result !== 32'd0) begin n_fail++; $display("FAIL prog_acc20 got=%0d exp=0", result); end
        n_chk++; if (dut.vreg[0] !== 32'h04030201) begin n_fail++; $display("FAIL prog_v0 got=%h exp=04030201", dut.vreg[0]); end
        n_chk++; if (dut.vreg[1] !== 32'h03030303) begin n_fail++; $display("FAIL prog_v1 got=%h exp=03030303", dut.vreg[1]); end
      end
      if (e == 25) begin
        n_chk++; if (result !== 32'd40) begin n_fail++; $display("FAIL prog_acc25 got=%0d exp=40", result); end
      end
      if (e == 30) begin
        n_chk++; if (dut.vreg[2] !== 32'hFF000102) begin n_fail++; $display("FAIL prog_v2_wrap got=%h exp=ff000102", dut.vreg[2]); end
      end
      if (e == 36) begin
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL prog_done_early got=%b exp=0", done); end
      end
      if (e == 37) begin
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL prog_done_37 got=%b exp=1", done); end
      end
    end
    repeat (463) @(posedge clk);
    #1;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL prog_done got=%b exp=1", done); end
    n_chk++; if (trap !== 1'b0) begin n_fail++; $display("FAIL prog_trap got=%b exp=0", trap); end
    n_chk++; if (result !== 32'h0000012A) begin n_fail++; $display("FAIL prog_result got=%h exp=0000012a", result); end
  endtask

  task automatic test_done_hold();
    repeat (400) @(posedge clk);
    #1;
    n_chk++; if (result !== 32'h0000012A) begin n_fail++; $display("FAIL hold_result got=%h exp=0000012a", result); end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b exp=1", done); end
    n_chk++; if (dut.pc !== 4'd8) begin n_fail++; $display("FAIL hold_pc got=%0d exp=8", dut.pc); end
    n_chk++; if (dut.vreg[3] !== 32'h100C0804) begin n_fail++; $display("FAIL hold_v3 got=%h exp=100c0804", dut.vreg[3]); end
    n_chk++; if (dut.vreg[2] !== 32'hFF000102) begin n_fail++; $display("FAIL hold_v2 got=%h exp=ff000102", dut.vreg[2]); end
  endtask

  task automatic test_midreset();
    restart();
    for (int e = 1; e <= 22; e++) edge_n();
    n_chk++; if (dut.vreg[3] !== 32'h100C0804) begin n_fail++; $display("FAIL mid_v3_pre got=%h exp=100c0804", dut.vreg[3]); end
    resetn = 1'b0;
    #1;
    n_chk++; if (dut.vreg !== 128'd0) begin n_fail++; $display("FAIL mid_vreg_clr got=%h exp=0", dut.vreg); end
    n_chk++; if (dut.pc !== 4'd0) begin n_fail++; $display("FAIL mid_pc_clr got=%0d exp=0", dut.pc); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done_clr got=%b exp=0", done); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int e = 1; e <= 37; e++) begin
      edge_n();
      if (e == 36) begin
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done_early got=%b exp=0", done); end
      end
    end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_done_37 got=%b exp=1", done); end
    n_chk++; if (result !== 32'd298) begin n_fail++; $display("FAIL mid_result got=%0d exp=298", result); end
  endtask

  task automatic test_trap();
    restart();
    for (int e = 1; e <= 10; e++) edge_n();
    n_chk++; if (dut.pc !== 4'd2) begin n_fail++; $display("FAIL trap_pc_pre got=%0d exp=2", dut.pc); end
    force dut.rom_word = 16'h7000;
    edge_n();
    release dut.rom_word;
    n_chk++; if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_early got=%b exp=0", trap); end
    edge_n();
    n_chk++; if (trap !== 1'b1) begin n_fail++; $display("FAIL trap_12 got=%b exp=1", trap); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL trap_done got=%b exp=0", done); end
    repeat (50) @(posedge clk);
    #1;
    n_chk++; if (dut.pc !== 4'd3) begin n_fail++; $display("FAIL trap_pc_frozen got=%0d exp=3", dut.pc); end
    n_chk++; if (result !== 32'd0) begin n_fail++; $display("FAIL trap_result got=%0d exp=0", result); end
    n_chk++; if (dut.vreg[2] !== 32'd0) begin n_fail++; $display("FAIL trap_v2 got=%h exp=0", dut.vreg[2]); end
    n_chk++; if (trap !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL trap_sticky trap=%b done=%b exp trap=1 done=0", trap, done); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_done_hold();
    test_midreset();
    test_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/final_module_sys.md
Name: final_module_sys

Overview:
- Self-contained vector-coprocessor demo system: internal program ROM, micro-sequencer, 4-entry vector register file, element-serial ALU, 32-bit scalar accumulator.
- Top of the vector-PCPI demo; the bench drives only clock and reset.
- Results are visible on status outputs, which the bench may leave unconnected and read hierarchically instead.

Parameters:
- VLEN, 4, elements per vector register.
- ELEN, 8, bits per element.
- ROM_DEPTH, 16, program ROM entries; PC width is clog2(ROM_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- done  output  1  HALT executed; sticky.
- trap  output  1  illegal opcode executed; sticky.
- result  output  32  scalar accumulator.

Behaviour:
- Reset (resetn=0, async): pc=0, state=FETCH, acc=0, done=0, trap=0, elem=0, all vector elements=0. Reset mid-program aborts and restarts from pc 0.
- Instruction word, 16 bits: [15:12] opcode, [11:10] vd, [9:8] vs1, [7:6] vs2, [7:0] imm. imm overlaps vs2; vs2 is ignored by imm ops.
- Opcodes:
  - 0 NOP.
  - 1 VSPLAT: vd[i]=imm.
  - 2 VADD: vd[i]=vs1[i]+vs2[i].
  - 3 VMUL: vd[i]=low ELEN bits of vs1[i]*vs2[i].
  - 4 VSUB: vd[i]=vs1[i]-vs2[i].
  - 5 VREDSUM: acc += zero-extended vs1[i] summed over i.
  - 6 VIDX: vd[i]=i+imm.
  - F HALT.
  - 7-E illegal.
- Element arithmetic wraps modulo 2^ELEN. Accumulator wraps modulo 2^32.
- FETCH (1 cycle): ir<=rom[pc]; pc<=pc+1, wrapping ROM_DEPTH-1 -> 0; go to EXEC with elem=0.
- EXEC, vector opcodes 1-6: one element per cycle, i=elem, for VLEN cycles; then FETCH. Each vector instruction costs 1+VLEN cycles.
- Same-register hazard: when vd equals a source, each element reads its own old value before writing.
- EXEC, NOP: 1 cycle, then FETCH.
- EXEC, HALT: 1 cycle; set done=1; enter DONE.
- EXEC, illegal: 1 cycle; set trap=1; enter DONE.
- DONE: absorbing until reset. No register, acc or pc changes.
- result is continuously driven from acc.
- ROM contents are fixed at elaboration:
  - 0 VIDX v0,1
  - 1 VSPLAT v1,3
  - 2 VMUL v2,v0,v1
  - 3 VADD v3,v2,v0
  - 4 VREDSUM v3
  - 5 VSUB v2,v1,v0
  - 6 VREDSUM v2
  - 7 HALT
  - 8-15 NOP
- Expected program state:
  - v0=[1,2,3,4], v1=[3,3,3,3].
  - v3=[4,8,12,16]; acc=40 after instruction 4.
  - v2=[2,1,0,255] after instruction 5.
  - Final acc=298 (0x0000012A).
- Timing: done rises on the 37th rising edge after resetn deasserts (7×5 + 2 cycles).

Optional Feature:
- Macro RETIRE_LOG_EN.
- When defined: on each instruction completion, a simulation-only $display prints retired pc, opcode and acc in hex.
- When undefined: no display code is compiled.
- Synthesized logic and cycle behaviour are identical in both cases.

Test Plan:
- Reset release, run 500 cycles -> done=1, trap=0, result=0x0000012A; done first high at edge 37 after release.
- Probe after instruction 3 completes (edge 20) -> v3=[4,8,12,16], acc=0. After edge 25 -> acc=40.
- Probe after instruction 5 (edge 30) -> v2=[2,1,0,0xFF], confirming wrap on 3-4.
- Assert resetn=0 at edge 22, release 3 cycles later -> all state clears immediately; rerun reaches done, result=298, 37 edges after the new release.
- Force the ROM entry at pc=2 to opcode 0x7 -> trap=1 on edge 12, done stays 0, result stays 0, pc frozen.
- Hold in DONE for 400 cycles -> result, done and registers unchanged.
